// File: rtl/dmem_port_ctrl_pkg.sv
// Shared constants and state encoding for the data-memory port controller.
package dmem_port_ctrl_pkg;

    localparam int unsigned DpcDataWidth = 32;
    localparam int unsigned DpcBeWidth   = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } dpc_state_e;

endpackage

// File: rtl/dpc_timeout_cnt.sv
// Bus-timeout counter: cleared on entry to BUSY, counts BUSY cycles,
// flags the last cycle the controller may wait for an ack.
module dpc_timeout_cnt #(
    parameter int unsigned Timeout = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(Timeout);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = (cnt_q == CntW'(Timeout - 1));

endmodule

// File: rtl/dmem_port_ctrl.sv
// Data-memory port controller: converts a MEM-stage load/store into a req/ack
// bus transaction, stalls the pipeline meanwhile and holds the loaded word.
module dmem_port_ctrl
    import dmem_port_ctrl_pkg::*;
#(
    parameter int unsigned RegDataWidth  = DpcDataWidth,
    parameter int unsigned ByteSlctWidth = DpcBeWidth,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned TIMEOUT       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ReadMem,
    input  logic                     WriteMem,
    input  logic [AddrWidth-1:0]     mem_addr_in,
    input  logic [ByteSlctWidth-1:0] byte_slct,
    input  logic [RegDataWidth-1:0]  wdata_in,
    input  logic                     hold_in,
    output logic [RegDataWidth-1:0]  raw_mem_data,
    output logic                     stall_req,
    output logic                     bus_err,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [AddrWidth-1:0]     mem_addr,
    output logic [ByteSlctWidth-1:0] mem_be,
    output logic [RegDataWidth-1:0]  mem_wdata,
    input  logic                     mem_ack,
    input  logic [RegDataWidth-1:0]  mem_rdata
);

    dpc_state_e               state_q;
    logic [RegDataWidth-1:0]  raw_q;
    logic                     bus_err_q;
    logic                     req_q;
    logic                     we_q;
    logic [AddrWidth-1:0]     addr_q;
    logic [ByteSlctWidth-1:0] be_q;
    logic [RegDataWidth-1:0]  wdata_q;

    logic new_req;
    logic start;
    logic expired;

    assign new_req = ReadMem | WriteMem;
    // A request seen while DONE is released belongs to the next instruction.
    assign start = new_req &
                   ((state_q == StIdle) | ((state_q == StDone) & ~hold_in));

    dpc_timeout_cnt #(
        .Timeout (TIMEOUT)
    ) u_timeout_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (start),
        .en_i      (state_q == StBusy),
        .expired_o (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            raw_q     <= '0;
            bus_err_q <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
        end else begin
            bus_err_q <= 1'b0;
            if (start) begin
                state_q <= StBusy;
                req_q   <= 1'b1;
                we_q    <= WriteMem;
                addr_q  <= mem_addr_in & ~AddrWidth'(3);
                be_q    <= byte_slct;
                wdata_q <= wdata_in;
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StBusy: begin
                        // Ack has priority over a simultaneous timeout.
                        if (mem_ack) begin
                            if (!we_q) begin
                                raw_q <= mem_rdata;
                            end
                            req_q   <= 1'b0;
                            state_q <= StDone;
                        end else if (expired) begin
                            raw_q     <= '0;
                            bus_err_q <= 1'b1;
                            req_q     <= 1'b0;
                            state_q   <= StDone;
                        end
                    end
                    StDone: begin
                        if (!hold_in) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign stall_req    = ((state_q == StIdle) & new_req) | (state_q == StBusy);
    assign raw_mem_data = raw_q;
    assign bus_err      = bus_err_q;
    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_be       = be_q;
    assign mem_wdata    = wdata_q;

endmodule
